// File: rtl/seven_segment_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package seven_segment_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OPEN = 2'd2
  } state_e;

  // Minimum ownership time in clock cycles: MHz * 1000 cycles per millisecond
  function automatic int hold_cycles_f(input int clk_mhz, input int hold_ms);
    return clk_mhz * 1000 * hold_ms;
  endfunction

endpackage

// File: rtl/seven_segment_arbiter_picker.sv
// Combinational round-robin picker: returns the first active request at or
// after 'start', wrapping past the highest index back to zero.
module round_robin_picker
  import seven_segment_pkg::*;
#(
  parameter int n_req = 3,
  localparam int idx_w = $clog2(n_req)
) (
  input  logic [n_req-1:0] req,
  input  logic [idx_w-1:0] start,
  output logic             valid,
  output logic [idx_w-1:0] index
);

  logic [n_req-1:0] rot_s;
  int               pos_s;

  // Rotate so that bit 0 corresponds to the requester at 'start'
  assign rot_s = n_req'({req, req} >> start);

  // Scan the rotated vector; the first set bit is the winner
  always_comb begin
    valid = 1'b0;
    index = {idx_w{1'b0}};
    pos_s = 0;
    for (int k = 0; k < n_req; k++) begin
      pos_s = (int'(start) + k >= n_req) ? int'(start) + k - n_req : int'(start) + k;
      if (!valid && rot_s[k]) begin
        valid = 1'b1;
        index = idx_w'(pos_s);
      end else begin
        index = index;
      end
    end
  end

endmodule

// File: rtl/seven_segment_arbiter.sv
// Seven-segment display arbiter: several requesters share one display; the
// owner keeps it for at least hold_cycles, then hands over round-robin.
// Optional macro SEVEN_SEGMENT_ARBITER_SNAPSHOT_EN: capture number/dots only
// when a grant is issued instead of following the owner's inputs live.
module seven_segment_arbiter
  import seven_segment_pkg::*;
#(
  parameter int n_req   = 3,
  parameter int w_digit = 2,
  parameter int clk_mhz = 50,
  parameter int hold_ms = 500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [n_req-1:0]           req,
  input  logic [n_req*w_digit*4-1:0] number_in,
  input  logic [n_req*w_digit-1:0]   dots_in,
  output logic [n_req-1:0]           grant,
  output logic [w_digit*4-1:0]       number,
  output logic [w_digit-1:0]         dots,
  output logic                       busy
);

  localparam int IDX_W       = $clog2(n_req);
  localparam int HOLD_CYCLES = hold_cycles_f(clk_mhz, hold_ms);
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  // HOLD ends as the counter steps onto hold_cycles-1, so together with the
  // single OPEN decision cycle the owner holds the display hold_cycles cycles.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

`ifdef SEVEN_SEGMENT_ARBITER_SNAPSHOT_EN
  localparam logic LIVE_EN = 1'b0;
`else
  localparam logic LIVE_EN = 1'b1;
`endif

  // One-hot vector for a requester index
  function automatic logic [n_req-1:0] onehot_f(input logic [IDX_W-1:0] i);
    return n_req'(1'b1) << i;
  endfunction

  // Successor index with wrap to zero
  function automatic logic [IDX_W-1:0] next_idx_f(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(n_req - 1)) ? {IDX_W{1'b0}} : i + IDX_W'(1'b1);
  endfunction

  state_e               state_r, state_next_s;
  logic [IDX_W-1:0]     owner_r, owner_next_s;
  logic [IDX_W-1:0]     last_owner_r, last_next_s;
  logic [CNT_W-1:0]     cnt_r, cnt_next_s, cnt_inc_s;
  logic [n_req-1:0]     grant_r, grant_next_s;
  logic                 busy_r;
  logic [w_digit*4-1:0] number_r, sel_number_s;
  logic [w_digit-1:0]   dots_r, sel_dots_s;
  logic                 load_s;
  logic [IDX_W-1:0]     load_idx_s;
  logic [n_req-1:0]     pick_req_s;
  logic [IDX_W-1:0]     pick_start_s;
  logic                 pick_valid_s;
  logic [IDX_W-1:0]     pick_idx_s;

  // Saturating increment of the hold counter
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1'b1);

  // Picker setup: in OPEN search past the owner excluding it, else past last owner
  always_comb begin
    pick_req_s   = req;
    pick_start_s = next_idx_f(last_owner_r);
    if (state_r == OPEN) begin
      pick_req_s   = req & ~onehot_f(owner_r);
      pick_start_s = next_idx_f(owner_r);
    end else begin
      pick_req_s   = req;
    end
  end

  round_robin_picker #(
    .n_req (n_req)
  ) u_picker (
    .req   (pick_req_s),
    .start (pick_start_s),
    .valid (pick_valid_s),
    .index (pick_idx_s)
  );

  // FSM next state, ownership bookkeeping and display load control
  always_comb begin
    state_next_s = state_r;
    owner_next_s = owner_r;
    last_next_s  = last_owner_r;
    cnt_next_s   = cnt_r;
    grant_next_s = grant_r;
    load_s       = 1'b0;
    load_idx_s   = owner_r;
    case (state_r)
      IDLE: begin
        grant_next_s = {n_req{1'b0}};
        if (pick_valid_s) begin
          state_next_s = HOLD;
          owner_next_s = pick_idx_s;
          grant_next_s = onehot_f(pick_idx_s);
          cnt_next_s   = {CNT_W{1'b0}};
          load_s       = 1'b1;
          load_idx_s   = pick_idx_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      HOLD: begin
        cnt_next_s = cnt_inc_s;
        load_s     = LIVE_EN;
        if (cnt_inc_s >= HOLD_LAST) begin
          state_next_s = OPEN;
        end else begin
          state_next_s = HOLD;
        end
      end
      OPEN: begin
        if (pick_valid_s) begin
          // Another requester takes over directly, no idle cycle
          state_next_s = HOLD;
          owner_next_s = pick_idx_s;
          grant_next_s = onehot_f(pick_idx_s);
          cnt_next_s   = {CNT_W{1'b0}};
          load_s       = 1'b1;
          load_idx_s   = pick_idx_s;
        end else if (req[owner_r]) begin
          state_next_s = OPEN;
          load_s       = LIVE_EN;
        end else begin
          state_next_s = IDLE;
          grant_next_s = {n_req{1'b0}};
          last_next_s  = owner_r;
          load_s       = LIVE_EN;
        end
      end
      default: begin
        state_next_s = IDLE;
        grant_next_s = {n_req{1'b0}};
      end
    endcase
  end

  // Select the display slice of the requester being loaded
  always_comb begin
    sel_number_s = number_r;
    sel_dots_s   = dots_r;
    for (int i = 0; i < n_req; i++) begin
      if (load_idx_s == IDX_W'(i)) begin
        sel_number_s = number_in[i*w_digit*4 +: w_digit*4];
        sel_dots_s   = dots_in[i*w_digit +: w_digit];
      end else begin
        sel_dots_s   = sel_dots_s;
      end
    end
  end

  // State, ownership and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= {IDX_W{1'b0}};
      last_owner_r <= IDX_W'(n_req - 1);
      cnt_r        <= {CNT_W{1'b0}};
      grant_r      <= {n_req{1'b0}};
      busy_r       <= 1'b0;
      number_r     <= {(w_digit*4){1'b0}};
      dots_r       <= {w_digit{1'b0}};
    end else begin
      state_r      <= state_next_s;
      owner_r      <= owner_next_s;
      last_owner_r <= last_next_s;
      cnt_r        <= cnt_next_s;
      grant_r      <= grant_next_s;
      busy_r       <= (state_next_s != IDLE);
      if (load_s) begin
        number_r <= sel_number_s;
        dots_r   <= sel_dots_s;
      end
    end
  end

  assign grant  = grant_r;
  assign busy   = busy_r;
  assign number = number_r;
  assign dots   = dots_r;

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Scoreboard bench for seven_segment_arbiter (n_req=3, w_digit=2,
// clk_mhz=1, hold_ms=1 -> 1000-cycle minimum ownership).
module tb_seven_segment_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] number_in;
  logic [5:0]  dots_in;
  logic [2:0]  grant;
  logic [7:0]  number;
  logic [1:0]  dots;
  logic        busy;

`ifdef SEVEN_SEGMENT_ARBITER_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] grant;
    logic [7:0] number;
    logic [1:0] dots;
    logic       busy;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] num_tbl[3];
  logic [1:0] dot_tbl[3];
  logic [7:0] cur_num;

  always #5 clk = ~clk;

  seven_segment_arbiter #(
    .n_req   (3),
    .w_digit (2),
    .clk_mhz (1),
    .hold_ms (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .number_in (number_in),
    .dots_in   (dots_in),
    .grant     (grant),
    .number    (number),
    .dots      (dots),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic expect_out(input logic [2:0] g, input logic [7:0] n, input logic [1:0] d);
    exp_t e;
    e.grant  = g;
    e.number = n;
    e.dots   = d;
    e.busy   = |g;
    exp_q.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_grant"},  32'(grant),  32'(e.grant));
      check({tag, "_number"}, 32'(number), 32'(e.number));
      check({tag, "_dots"},   32'(dots),   32'(e.dots));
      check({tag, "_busy"},   32'(busy),   32'(e.busy));
    end
  endtask

  task automatic apply_data();
    number_in = {num_tbl[2], num_tbl[1], num_tbl[0]};
    dots_in   = {dot_tbl[2], dot_tbl[1], dot_tbl[0]};
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    expect_out(3'b000, 8'h00, 2'b00);
    tick(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req        = 3'b000;
    num_tbl[0] = 8'h12; num_tbl[1] = 8'h9C; num_tbl[2] = 8'h7E;
    dot_tbl[0] = 2'b01; dot_tbl[1] = 2'b10; dot_tbl[2] = 2'b11;
    apply_data();

    // Reset state, first grant, hold through owner drop, live/snapshot data
    do_reset("rst0");
    req = 3'b011;
    expect_out(3'b001, 8'h12, 2'b01);
    tick("grant_first");
    cur_num = 8'h12;
    for (int c = 2; c <= 1000; c++) begin
      if (c == 6) begin
        num_tbl[0] = 8'h34;
        apply_data();
        if (!SNAP_EN) cur_num = 8'h34;
      end
      req = (c < 10) ? 3'b001 : 3'b000;
      expect_out(3'b001, cur_num, 2'b01);
      tick("hold0");
    end
    expect_out(3'b000, cur_num, 2'b01);
    tick("release");
    expect_out(3'b000, cur_num, 2'b01);
    tick("idle_keep");

    // Round robin with all requesters active: 001, 010, 100, 001
    num_tbl[0] = 8'h12;
    apply_data();
    do_reset("rst1");
    req = 3'b111;
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 1000; c++) begin
        expect_out(3'b001 << t, num_tbl[t], dot_tbl[t]);
        tick("rr_seq");
      end
    end
    for (int c = 0; c < 10; c++) begin
      expect_out(3'b001, num_tbl[0], dot_tbl[0]);
      tick("rr_wrap");
    end

    // Reset in the middle of HOLD, then a lone requester 2
    do_reset("rst_mid_hold");
    req = 3'b100;
    expect_out(3'b100, num_tbl[2], dot_tbl[2]);
    tick("after_rst");
    expect_out(3'b100, num_tbl[2], dot_tbl[2]);
    tick("after_rst_hold");

    // Requester 1 alone: keeps ownership well past the hold, then loses it
    do_reset("rst2");
    req = 3'b010;
    for (int c = 1; c <= 6000; c++) begin
      expect_out(3'b010, num_tbl[1], dot_tbl[1]);
      tick("own1");
    end
    req = 3'b110;
    expect_out(3'b100, num_tbl[2], dot_tbl[2]);
    tick("takeover");
    req = 3'b000;
    expect_out(3'b100, num_tbl[2], dot_tbl[2]);
    tick("takeover_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
